// File: rtl/run_detect_scheduler.sv
// Round-robin scheduler sharing one saturating consecutive-ones run detector among NUM_CH serial channels.
// Define RUN_DETECT_SCHED_HITCNT_EN to add the 16-bit hit_cnt output and its hit_clr input.
module run_detect_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 2,
    parameter int THRESH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         bit_in,
    output logic [NUM_CH-1:0]         gnt,
    input  logic [NUM_CH-1:0]         clr,
    output logic                      res_valid,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic                      res_out,
    output logic [CNT_W-1:0]          res_cnt
`ifdef RUN_DETECT_SCHED_HITCNT_EN
    ,
    input  logic                      hit_clr,
    output logic [15:0]               hit_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic             res_valid_q, res_valid_d;
    logic [IDX_W-1:0] res_ch_q, res_ch_d;
    logic             res_out_q, res_out_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

    logic             found;
    logic [IDX_W-1:0] gnt_idx;
    logic [CNT_W-1:0] new_cnt;
    int               idx;

    // Grant is held at zero while reset is asserted, so nothing is granted during that cycle.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = 0;
        if (reset) begin
            for (int off = 0; off < NUM_CH; off++) begin
                idx = (int'(ptr_q) + off) % NUM_CH;
                if (!found && req[idx]) begin
                    found   = 1'b1;
                    gnt_idx = idx[IDX_W-1:0];
                end
            end
            if (found) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        new_cnt     = '0;
        ptr_d       = ptr_q;
        res_valid_d = found;
        res_ch_d    = res_ch_q;
        res_out_d   = res_out_q;
        res_cnt_d   = res_cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr[i]) begin
                cnt_d[i] = '0;
            end
        end
        if (found) begin
            // A clear on the granted channel wins: the sample is consumed but the run restarts at 0.
            if (clr[gnt_idx]) begin
                new_cnt = '0;
            end else if (bit_in[gnt_idx]) begin
                new_cnt = (cnt_q[gnt_idx] == CNT_MAX) ? CNT_MAX : cnt_q[gnt_idx] + CNT_W'(1);
            end
            cnt_d[gnt_idx] = new_cnt;
            ptr_d          = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
            res_ch_d       = gnt_idx;
            res_cnt_d      = new_cnt;
            res_out_d      = (int'(new_cnt) >= THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_out_q   <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_out_q   <= res_out_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_out   = res_out_q;
    assign res_cnt   = res_cnt_q;

`ifdef RUN_DETECT_SCHED_HITCNT_EN
    logic [15:0] hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        if (hit_clr) begin
            hit_d = '0;
        end else if (found && res_out_d && (hit_q != 16'hFFFF)) begin
            hit_d = hit_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Directed and randomized check of run_detect_scheduler against a spec-level reference model.
module tb_run_detect_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 2;
    localparam int THRESH = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_CH-1:0]         req = '0;
    logic [NUM_CH-1:0]         bit_in = '0;
    logic [NUM_CH-1:0]         clr = '0;
    logic [NUM_CH-1:0]         gnt;
    logic                      res_valid;
    logic [$clog2(NUM_CH)-1:0] res_ch;
    logic                      res_out;
    logic [CNT_W-1:0]          res_cnt;
`ifdef RUN_DETECT_SCHED_HITCNT_EN
    logic                      hit_clr = 1'b0;
    logic [15:0]               hit_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_cnt [NUM_CH];
    int m_ptr = 0;
    int m_valid = 0;
    int m_ch = 0;
    int m_res_cnt = 0;
    int m_out = 0;
    int m_hit = 0;

    run_detect_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bit_in    (bit_in),
        .gnt       (gnt),
        .clr       (clr),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_out   (res_out),
        .res_cnt   (res_cnt)
`ifdef RUN_DETECT_SCHED_HITCNT_EN
        ,
        .hit_clr   (hit_clr),
        .hit_cnt   (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_results();
        check_output("res_valid", 32'(res_valid), 32'(m_valid));
        check_output("res_ch", 32'(res_ch), 32'(m_ch));
        check_output("res_cnt", 32'(res_cnt), 32'(m_res_cnt));
        check_output("res_out", 32'(res_out), 32'(m_out));
`ifdef RUN_DETECT_SCHED_HITCNT_EN
        check_output("hit_cnt", 32'(hit_cnt), 32'(m_hit));
`endif
    endtask

    // One cycle with reset asserted; req/bit_in are driven to show gnt stays low.
    task automatic apply_reset(input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] b);
        @(negedge clk);
        reset = 1'b0;
        req = r;
        bit_in = b;
        clr = '0;
        #1;
        check_output("gnt_in_reset", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        m_ptr = 0;
        m_valid = 0;
        m_ch = 0;
        m_res_cnt = 0;
        m_out = 0;
        m_hit = 0;
        check_results();
        reset = 1'b1;
    endtask

    // One clocked cycle: check gnt before the edge and results after it.
    task automatic apply_stimulus(input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] b,
                                  input logic [NUM_CH-1:0] c, input bit hclr);
        int k;
        int nv;
        int exp_gnt;
        @(negedge clk);
        req = r;
        bit_in = b;
        clr = c;
`ifdef RUN_DETECT_SCHED_HITCNT_EN
        hit_clr = hclr;
`endif
        #1;
        k = -1;
        for (int off = 0; off < NUM_CH; off++) begin
            if (k < 0 && r[(m_ptr + off) % NUM_CH]) k = (m_ptr + off) % NUM_CH;
        end
        exp_gnt = (k < 0) ? 0 : (1 << k);
        check_output("gnt", 32'(gnt), 32'(exp_gnt));
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c[i]) m_cnt[i] = 0;
        end
        if (k >= 0) begin
            if (c[k]) nv = 0;
            else if (b[k]) nv = (m_cnt[k] + 1 > MAXC) ? MAXC : m_cnt[k] + 1;
            else nv = 0;
            m_cnt[k] = nv;
            m_valid = 1;
            m_ch = k;
            m_res_cnt = nv;
            m_out = (nv >= THRESH) ? 1 : 0;
            m_ptr = (k + 1) % NUM_CH;
        end else begin
            m_valid = 0;
        end
        if (hclr) m_hit = 0;
        else if (k >= 0 && m_out == 1 && m_hit < 65535) m_hit = m_hit + 1;
        check_results();
`ifdef RUN_DETECT_SCHED_HITCNT_EN
        hit_clr = 1'b0;
`endif
    endtask

    initial begin
        logic [NUM_CH-1:0] seq_bits;
        logic [NUM_CH-1:0] rr, rb, rc;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;

        $display("[TB] reset");
        apply_reset(4'b1111, 4'b1111);

        $display("[TB] single channel run 1,1,1,1,0,1");
        seq_bits = 4'b0000;
        for (int s = 0; s < 6; s++) begin
            seq_bits[0] = (s == 4) ? 1'b0 : 1'b1;
            apply_stimulus(4'b0001, seq_bits, 4'b0000, 1'b0);
        end
        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);

        $display("[TB] contention, all channels requesting");
        apply_reset(4'b0000, 4'b0000);
        for (int s = 0; s < 8; s++) apply_stimulus(4'b1111, 4'b1111, 4'b0000, 1'b0);

        $display("[TB] interleaving channels 0 and 1");
        apply_reset(4'b0000, 4'b0000);
        apply_stimulus(4'b0011, 4'b0011, 4'b0000, 1'b0);
        apply_stimulus(4'b0011, 4'b0011, 4'b0000, 1'b0);
        apply_stimulus(4'b0011, 4'b0011, 4'b0000, 1'b0);
        apply_stimulus(4'b0011, 4'b0001, 4'b0000, 1'b0);

        $display("[TB] clear collision on channel 3");
        apply_reset(4'b0000, 4'b0000);
        for (int s = 0; s < 3; s++) apply_stimulus(4'b1000, 4'b1000, 4'b0000, 1'b0);
        apply_stimulus(4'b1000, 4'b1000, 4'b1000, 1'b0);
        apply_stimulus(4'b1000, 4'b1000, 4'b0000, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 4'b0100, 1'b0);

        $display("[TB] reset mid-run on channel 2");
        apply_reset(4'b0000, 4'b0000);
        apply_stimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
        apply_stimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
        apply_reset(4'b0100, 4'b0100);
        apply_stimulus(4'b1100, 4'b0100, 4'b0000, 1'b0);

        $display("[TB] randomized traffic");
        for (int s = 0; s < 300; s++) begin
            rr = NUM_CH'($urandom_range(0, 15));
            rb = NUM_CH'($urandom_range(0, 15));
            rc = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom_range(0, 15)) : '0;
            if ($urandom_range(0, 39) == 0) apply_reset(rr, rb);
            else apply_stimulus(rr, rb, rc, ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/run_detect_scheduler.md
Name: run_detect_scheduler

Overview:
- Shares one consecutive-ones run detector among NUM_CH serial requesters.
- The detector is a saturating run counter; its output asserts once a run of at least THRESH ones has been seen.
- Keeps a saved run count per channel and grants one channel per cycle, round-robin.
- Applies the granted bit to that channel's saved count and returns a tagged result one cycle later.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- CNT_W, 2, width of each per-channel run counter. The counter saturates at 2^CNT_W-1.
- THRESH, 2, run length at or above which the result is 1. Legal range is 1..2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset. reset=0 at a rising clk edge resets the block.
- req  input  NUM_CH  per-channel request. Held until granted.
- bit_in  input  NUM_CH  per-channel sample bit. Valid while req[i]=1.
- gnt  output  NUM_CH  one-hot grant, combinational from req and the priority pointer. A transfer occurs when req[i] & gnt[i].
- clr  input  NUM_CH  per-channel state clear.
- res_valid  output  1  registered; high for one cycle per processed sample.
- res_ch  output  $clog2(NUM_CH)  channel index of the result.
- res_out  output  1  1 when the updated count >= THRESH.
- res_cnt  output  CNT_W  updated run count.

Behaviour:
- Reset (reset=0 at posedge):
  - All per-channel counts go to 0 and the priority pointer goes to 0.
  - res_valid, res_ch, res_out and res_cnt go to 0.
  - gnt is 0 during that cycle, independent of req.
- Arbitration:
  - Round-robin starting at the pointer ptr. gnt selects the first i, scanning ptr, ptr+1, ... mod NUM_CH, with req[i]=1.
  - gnt is all-zero when req is all-zero.
  - After a grant to channel k, ptr <= (k+1) mod NUM_CH. With no grant, ptr holds.
- Detector update for granted channel k, per cycle:
  - If bit_in[k]=1: cnt[k] <= min(cnt[k]+1, 2^CNT_W-1). Saturate, never wrap.
  - If bit_in[k]=0: cnt[k] <= 0.
- Result latency is exactly 1 cycle. The edge that updates cnt[k] also registers:
  - res_valid=1, res_ch=k.
  - res_cnt = new cnt[k].
  - res_out = (new cnt[k] >= THRESH).
- Idle cycles: a cycle with no grant gives res_valid=0 next cycle. res_ch, res_cnt and res_out hold their last values.
- Clear:
  - clr[i]=1 sets cnt[i] to 0 at the edge.
  - If channel i is also granted in the same cycle, clear has priority. cnt[i] <= 0 and the sample is consumed (the grant is still issued).
  - In that case the result shows res_cnt=0, res_out=0, res_valid=1.
- Channel independence: a sample on channel j never modifies cnt[i] for i≠j.
- Reset mid-run: any in-flight result is dropped. res_valid is 0 in the cycle after reset, and all runs restart from 0.
- Starvation bound: a requester holding req is granted within NUM_CH cycles.

Optional Feature:
- Macro RUN_DETECT_SCHED_HITCNT_EN.
- When defined:
  - Adds output hit_cnt (16 bits) and input hit_clr (1 bit).
  - hit_cnt increments by 1 on every cycle where res_valid=1 and res_out=1 are registered. It saturates at 0xFFFF.
  - hit_clr=1 zeros hit_cnt. This takes priority over a same-cycle increment.
  - Reset zeros hit_cnt.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Single channel, default parameters. Apply bit_in[0] sequence 1,1,1,1,0,1 with req[0] held.
  - Required: res_cnt = 1,2,3,3,0,1 and res_out = 0,1,1,1,0,0.
  - Each result appears 1 cycle after its grant, with res_ch=0.
- Contention: req=4'b1111 held for 8 cycles from reset.
  - Required: gnt = 0001,0010,0100,1000,0001,0010,0100,1000.
  - Each channel's count advances independently: with all bits 1, channel 2 reaches res_cnt=2 on its second grant.
- Interleaving: channels 0 and 1 alternate grants.
  - Channel 0 sees 1,1 and channel 1 sees 1,0.
  - Required: channel 0 ends at count 2 with res_out=1; channel 1 ends at count 0 with res_out=0.
- Clear collision: channel 3 count is 3. Assert clr[3] and grant channel 3 with bit=1 in the same cycle.
  - Required result: res_cnt=0, res_out=0, res_valid=1.
  - The next bit=1 on channel 3 gives res_cnt=1.
- Reset mid-run: reset=0 in the same cycle as a grant to channel 2 while cnt[2]=2.
  - Required: res_valid=0 next cycle and ptr=0.
  - The next grant to channel 2 with bit=1 gives res_cnt=1.
- With RUN_DETECT_SCHED_HITCNT_EN defined: the first scenario gives hit_cnt=3. A following hit_clr pulse gives hit_cnt=0.
